key_dispatch: RTL and testbench
===============================

// Module: key_dispatch
// PURPOSE
//  Mode controller/scheduler for debounced key events. Takes one-cycle key codes
//  (1..5) from the key debouncer, queues them in order, and routes each to the
//  menu consumer or the game consumer over a valid/ready handshake.
//  Runs the MENU/PLAY/PAUSE mode FSM. Code 5 (centre) is a control key.
// PARAMETERS
//  DEPTH     4              event FIFO depth (power of 2, >=2)
//  TO_W      30             width of pause-timeout counter
//  PAUSE_TO  30'd1000000000 cycles in PAUSE before auto-return to MENU (10 s @100 MHz)
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst_n      in   1  asynchronous active-low reset
//  key_code   in   3  debounced key code; nonzero for exactly one cycle per press
//  game_over  in   1  one-cycle pulse from game logic
//  menu_rdy   in   1  menu consumer ready
//  game_rdy   in   1  game consumer ready
//  menu_valid out  1  menu_code valid
//  menu_code  out  3  key code to menu (1..4)
//  game_valid out  1  game_code valid
//  game_code  out  3  key code to game (1..4)
//  mode       out  2  0=MENU 1=PLAY 2=PAUSE (3 unused, never driven)
//  drop_cnt   out  8  count of key events lost to FIFO full; saturates at 255
// BEHAVIOUR
//  Reset (async, rst_n=0): mode=MENU, FIFO empty, timeout cnt=0, drop_cnt=0,
//   menu_valid=game_valid=0, codes=0. Release takes effect on the next clk edge.
//  Enqueue: key_code in 1..5 pushed on clk edge if FIFO not full. Codes 0, 6, 7
//   are ignored. Full: event dropped, drop_cnt+1 (sat at 255). A push into a full
//   FIFO is dropped even if a pop happens in the same cycle.
//  Head processing, strictly in order, one event per cycle max:
//   head==5: popped unconditionally on next edge, no output. MENU->PLAY,
//    PLAY->PAUSE, PAUSE->PLAY.
//   head 1..4, MENU: menu_valid=1, menu_code=head; pop on edge with menu_rdy=1.
//   head 1..4, PLAY: game_valid=1, game_code=head; pop on edge with game_rdy=1.
//   head 1..4, PAUSE: popped and discarded next edge, drop_cnt unchanged.
//  valid/code are derived from registered FIFO head and mode only, with no
//   comb path from rdy or key_code. Once asserted, code is held stable until
//   transfer. The only exception is flush, which deasserts valid without transfer.
//  Latency: key pulse at cycle N into empty FIFO -> valid at N+1.
//   Code 5 at cycle N -> mode changes at N+2.
//  Only one of menu_valid/game_valid is ever 1. Each is 0 while the FIFO is empty.
//  Timeout: cnt cleared on PAUSE entry and +1 each cycle in PAUSE.
//   When cnt==PAUSE_TO-1: mode->MENU and FIFO flushed.
//  game_over=1 in PLAY or PAUSE: mode->MENU and FIFO flushed. Ignored in MENU.
//  Flush priority: flush beats a same-cycle push (new code discarded, not counted)
//   and a same-cycle head action.
//  Pointers: log2(DEPTH)+1 bits, wrap naturally. full = MSBs differ and rest equal.
// TESTING
//  1 reset mid-stream: 3 codes queued, mode=PAUSE, pull rst_n low -> all outputs
//   at reset values immediately, before the next clk edge.
//  2 MENU, menu_rdy=1, key 2 at N -> menu_valid=1, menu_code=2 at N+1; popped at
//   edge N+1. game_valid never 1.
//  3 keys 5 then 3, game_rdy=0 -> mode=PLAY, game_valid=1, game_code=3 held 10 cycles
//   stable. Raise game_rdy -> exactly one transfer.
//  4 PLAY, game_rdy=0, send 6 keys of code 1 -> FIFO holds 4, drop_cnt=2;
//   send 300 more -> drop_cnt=255.
//  5 PLAY, key 5 -> PAUSE; keys 1,2 discarded with drop_cnt unchanged; PAUSE_TO=16
//   -> mode=MENU exactly 16 cycles after PAUSE entry.
//  6 PLAY, FIFO 2 deep, game_over coincident with key 4 -> mode=MENU, FIFO empty,
//   no valid asserted, drop_cnt unchanged.

Source files
------------

// File: rtl/key_dispatch.sv
// Key event scheduler: queues debounced key codes and routes them to the menu or
// game consumer according to the MENU/PLAY/PAUSE mode FSM.
module key_dispatch #(
   parameter int              DEPTH    = 4,
   parameter int              TO_W     = 30,
   parameter logic [TO_W-1:0] PAUSE_TO = 30'd1000000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] key_code,
   input  logic       game_over,
   input  logic       menu_rdy,
   input  logic       game_rdy,
   output logic       menu_valid,
   output logic [2:0] menu_code,
   output logic       game_valid,
   output logic [2:0] game_code,
   output logic [1:0] mode,
   output logic [7:0] drop_cnt
);

   localparam int              AW      = $clog2(DEPTH);
   localparam logic [1:0]      MENU    = 2'd0;
   localparam logic [1:0]      PLAY    = 2'd1;
   localparam logic [1:0]      PAUSE   = 2'd2;
   localparam logic [2:0]      CTRL    = 3'd5;
   localparam logic [TO_W-1:0] TO_LAST = PAUSE_TO - TO_W'(1);

   logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
   logic [2:0]       mem_q [DEPTH];
   logic [2:0]       mem_d [DEPTH];
   logic [1:0]       mode_q, mode_d;
   logic [TO_W-1:0]  cnt_q, cnt_d;
   logic [7:0]       drop_q, drop_d;

   logic       empty, full, key_ok, flush, head_key, pop;
   logic [2:0] head;

   assign empty    = (wr_q == rd_q);
   assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign head     = mem_q[rd_q[AW-1:0]];
   assign head_key = !empty && (head != CTRL);
   assign key_ok   = (key_code != 3'd0) && (key_code <= CTRL);
   assign flush    = ((mode_q == PAUSE) && (cnt_q == TO_LAST)) ||
                     (game_over && (mode_q != MENU));

   // Outputs depend only on registered head/mode, so code stays put until transfer.
   assign menu_valid = head_key && (mode_q == MENU);
   assign game_valid = head_key && (mode_q == PLAY);
   assign menu_code  = menu_valid ? head : 3'd0;
   assign game_code  = game_valid ? head : 3'd0;
   assign mode       = mode_q;
   assign drop_cnt   = drop_q;

   always_comb begin
      wr_d   = wr_q;
      rd_d   = rd_q;
      mem_d  = mem_q;
      mode_d = mode_q;
      drop_d = drop_q;
      cnt_d  = (mode_q == PAUSE) ? cnt_q + TO_W'(1) : '0;
      pop    = 1'b0;
      if (flush) begin
         rd_d   = wr_q;
         mode_d = MENU;
         cnt_d  = '0;
      end else begin
         // Full is judged on registered pointers: a same-cycle pop does not make room.
         if (key_ok) begin
            if (full) begin
               if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end else begin
               mem_d[wr_q[AW-1:0]] = key_code;
               wr_d = wr_q + (AW+1)'(1);
            end
         end
         if (!empty) begin
            pop = (head == CTRL) || (mode_q == PAUSE) ||
                  (menu_valid && menu_rdy) || (game_valid && game_rdy);
            if (head == CTRL) begin
               case (mode_q)
                  MENU:    mode_d = PLAY;
                  PLAY:    mode_d = PAUSE;
                  PAUSE:   mode_d = PLAY;
                  default: mode_d = MENU;
               endcase
            end
            if (pop) rd_d = rd_q + (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q   <= '0;
         rd_q   <= '0;
         mode_q <= MENU;
         cnt_q  <= '0;
         drop_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         mode_q <= mode_d;
         cnt_q  <= cnt_d;
         drop_q <= drop_d;
         mem_q  <= mem_d;
      end
   end

endmodule

// File: tb/tb_key_dispatch.sv
// Directed bench for key_dispatch: hand-computed expectations, PAUSE_TO shortened to 16.
module tb_key_dispatch;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] key_code = 3'd0;
   logic       game_over = 1'b0;
   logic       menu_rdy = 1'b0;
   logic       game_rdy = 1'b0;
   logic       menu_valid, game_valid;
   logic [2:0] menu_code, game_code;
   logic [1:0] mode;
   logic [7:0] drop_cnt;

   int checks = 0;
   int failures = 0;
   int game_xfer = 0;
   int x0;

   key_dispatch #(.DEPTH(4), .TO_W(30), .PAUSE_TO(30'd16)) dut (
      .clk(clk), .rst_n(rst_n), .key_code(key_code), .game_over(game_over),
      .menu_rdy(menu_rdy), .game_rdy(game_rdy),
      .menu_valid(menu_valid), .menu_code(menu_code),
      .game_valid(game_valid), .game_code(game_code),
      .mode(mode), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (game_valid && game_rdy) game_xfer <= game_xfer + 1;

   // Never-both-valid invariant checked on every falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         assert (!(menu_valid && game_valid)) else begin
            failures++;
            $error("FAIL both_valid obs=%0b%0b exp=not both", menu_valid, game_valid);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic key(input logic [2:0] k);
      key_code = k;
      tick();
      key_code = 3'd0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_mv"}, {31'd0, menu_valid}, 0);
      chk({tag, "_gv"}, {31'd0, game_valid}, 0);
      chk({tag, "_mc"}, {29'd0, menu_code}, 0);
      chk({tag, "_gc"}, {29'd0, game_code}, 0);
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_mode", {30'd0, mode}, 0);
      chk("rst_drop", {24'd0, drop_cnt}, 0);
      chk_idle("rst");
      tick();
      rst_n = 1'b1;

      // MENU routing: key 2 -> valid next cycle, popped on that edge
      menu_rdy = 1'b1;
      key(3'd2);
      chk("menu_v", {31'd0, menu_valid}, 1);
      chk("menu_c", {29'd0, menu_code}, 2);
      chk("menu_gv", {31'd0, game_valid}, 0);
      tick();
      chk("menu_pop", {31'd0, menu_valid}, 0);
      menu_rdy = 1'b0;

      // Key 5 then 3: PLAY, code 3 held while game_rdy=0
      key(3'd5);
      chk("c5_nov", {31'd0, menu_valid}, 0);
      chk("c5_mode_n1", {30'd0, mode}, 0);
      key(3'd3);
      chk("play_mode", {30'd0, mode}, 1);
      for (int i = 0; i < 10; i++) begin
         chk("hold_v", {31'd0, game_valid}, 1);
         chk("hold_c", {29'd0, game_code}, 3);
         tick();
      end
      x0 = game_xfer;
      game_rdy = 1'b1;
      tick();
      chk("xfer_v", {31'd0, game_valid}, 0);
      tick();
      tick();
      chk("xfer_cnt", game_xfer - x0, 1);
      game_rdy = 1'b0;

      // Overflow: 6 keys into depth 4 -> 2 drops
      for (int i = 0; i < 6; i++) key(3'd1);
      chk("ovf_drop", {24'd0, drop_cnt}, 2);
      chk("ovf_gv", {31'd0, game_valid}, 1);
      // push into full FIFO with same-cycle pop still drops
      game_rdy = 1'b1;
      key(3'd1);
      game_rdy = 1'b0;
      chk("ovf_poppush", {24'd0, drop_cnt}, 3);
      key(3'd7);
      key(3'd0);
      chk("ign_67", {24'd0, drop_cnt}, 3);
      for (int i = 0; i < 300; i++) key(3'd1);
      chk("sat_drop", {24'd0, drop_cnt}, 255);
      game_rdy = 1'b1;
      tick(); tick(); tick();
      chk("drain3_v", {31'd0, game_valid}, 1);
      tick();
      chk("drain4_v", {31'd0, game_valid}, 0);
      game_rdy = 1'b0;

      // Reset mid-stream: queue codes, drop_cnt nonzero, mid-cycle reset
      key(3'd1); key(3'd2); key(3'd3);
      chk("pre_rst_gv", {31'd0, game_valid}, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_mode", {30'd0, mode}, 0);
      chk("arst_drop", {24'd0, drop_cnt}, 0);
      chk_idle("arst");
      tick();
      rst_n = 1'b1;
      tick();
      chk_idle("post_rst");

      // PAUSE discards and timeout
      key(3'd5);
      tick();
      chk("t5_play", {30'd0, mode}, 1);
      key(3'd5);
      key(3'd1);   // edge E: enter PAUSE, push 1
      chk("pause_mode", {30'd0, mode}, 2);
      key(3'd2);   // E+1
      chk_idle("pause_a");
      tick();      // E+2
      chk_idle("pause_b");
      chk("pause_drop", {24'd0, drop_cnt}, 0);
      for (int i = 0; i < 13; i++) tick();   // E+15
      chk("to_m1", {30'd0, mode}, 2);
      tick();      // E+16
      chk("to_menu", {30'd0, mode}, 0);

      // game_over in PLAY with 2 queued and coincident key
      key(3'd5);
      tick();
      chk("t6_play", {30'd0, mode}, 1);
      key(3'd1); key(3'd2);
      chk("t6_gc", {29'd0, game_code}, 1);
      key_code = 3'd4;
      game_over = 1'b1;
      tick();
      key_code = 3'd0;
      game_over = 1'b0;
      chk("go_mode", {30'd0, mode}, 0);
      chk("go_drop", {24'd0, drop_cnt}, 0);
      chk_idle("go_a");
      tick();
      chk_idle("go_b");

      // game_over ignored in MENU
      key(3'd3);
      game_over = 1'b1;
      tick();
      game_over = 1'b0;
      chk("gom_mode", {30'd0, mode}, 0);
      chk("gom_mv", {31'd0, menu_valid}, 1);
      chk("gom_mc", {29'd0, menu_code}, 3);
      menu_rdy = 1'b1;
      tick();
      chk("gom_pop", {31'd0, menu_valid}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout obs=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
